apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/apb_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB widths and the transfer-state encoding used by the request arbiter.
package apb_pkg;

   localparam int APB_ADDR_W = 11;
   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector; the search starts at the pointer, and the pointer
// moves past the winner only when the caller strobes advance.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_next_ptr;
   int               w_idx;

   // Walk from the farthest offset down so the requester nearest the pointer wins.
   always_comb begin
      o_grant    = '0;
      w_next_ptr = r_ptr;
      w_idx      = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_idx = (int'(r_ptr) + off) % NUM_REQ;
         if (i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            w_next_ptr     = PTR_W'((w_idx + 1) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= w_next_ptr;
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Bridges NUM_REQ command requesters onto one APB completer, one transfer at a time,
// with round-robin selection and an optional ACCESS-phase wait timeout.
module apb_req_arbiter
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*APB_STRB_W-1:0] req_strb,
   input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [APB_DATA_W-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic [APB_ADDR_W-1:0]         paddr,
   output logic                          pwrite,
   output logic                          psel,
   output logic                          penable,
   output logic [APB_STRB_W-1:0]         pstrb,
   output logic [APB_DATA_W-1:0]         pwdata,
   input  logic [APB_DATA_W-1:0]         prdata,
   input  logic                          pready,
   input  logic                          pslverr,
   output logic                          busy,
   output apb_state_e                    o_dbg_state
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_state_e              r_state;
   logic [NUM_REQ-1:0]      r_grant;
   logic [APB_ADDR_W-1:0]   r_paddr;
   logic                    r_pwrite;
   logic [APB_STRB_W-1:0]   r_pstrb;
   logic [APB_DATA_W-1:0]   r_pwdata;
   logic                    r_psel;
   logic                    r_penable;
   logic [CNT_W-1:0]        r_wait_cnt;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [APB_DATA_W-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;

   logic [NUM_REQ-1:0]      w_grant;
   logic                    w_accept;
   logic [APB_ADDR_W-1:0]   w_addr;
   logic                    w_write;
   logic [APB_STRB_W-1:0]   w_strb;
   logic [APB_DATA_W-1:0]   w_wdata;

   // Handshake: a command transfers on a cycle where req_valid[i] and req_ready[i]
   // are both high; req_ready is offered only in IDLE, only to the arbiter winner.
   assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
   assign req_ready = w_grant & {NUM_REQ{(r_state == ST_IDLE) && rst_n}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req_valid),
      .i_advance (w_accept),
      .o_grant   (w_grant)
   );

   always_comb begin
      w_addr  = '0;
      w_write = 1'b0;
      w_strb  = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_addr  = req_addr[i*APB_ADDR_W +: APB_ADDR_W];
            w_write = req_write[i];
            w_strb  = req_strb[i*APB_STRB_W +: APB_STRB_W];
            w_wdata = req_wdata[i*APB_DATA_W +: APB_DATA_W];
         end
      end
   end

   // Completer inputs are only looked at in ACCESS; the response goes out the cycle after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_paddr     <= '0;
         r_pwrite    <= 1'b0;
         r_pstrb     <= '0;
         r_pwdata    <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_wait_cnt  <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_SETUP;
                  r_psel   <= 1'b1;
                  r_grant  <= w_grant;
                  r_paddr  <= w_addr;
                  r_pwrite <= w_write;
                  r_pstrb  <= w_write ? w_strb : '0;
                  r_pwdata <= w_wdata;
               end
            end
            ST_SETUP: begin
               r_state    <= ST_ACCESS;
               r_penable  <= 1'b1;
               r_wait_cnt <= '0;
            end
            ST_ACCESS: begin
               if (pready) begin
                  r_state     <= ST_IDLE;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= r_grant;
                  r_rsp_rdata <= r_pwrite ? '0 : prdata;
                  r_rsp_err   <= pslverr;
               end else if ((TIMEOUT != 0) && (r_wait_cnt == TO_LAST)) begin
                  r_state     <= ST_IDLE;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= r_grant;
                  r_rsp_err   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
            end
         endcase
      end
   end

   assign paddr       = r_paddr;
   assign pwrite      = r_pwrite;
   assign pstrb       = r_pstrb;
   assign pwdata      = r_pwdata;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign busy        = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: two requesters, TIMEOUT=4 so the timeout path is reachable.
module tb_apb_req_arbiter;
   import apb_pkg::*;

   localparam int N = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*11-1:0]   req_addr;
   logic [N-1:0]      req_write;
   logic [N*4-1:0]    req_strb;
   logic [N*32-1:0]   req_wdata;
   logic [N-1:0]      rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [10:0]       paddr;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [3:0]        pstrb;
   logic [31:0]       pwdata;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;
   logic              busy;
   apb_state_e        dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [N-1:0] exp_q[$];

   apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_strb(req_strb), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
      .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .busy(busy), .o_dbg_state(dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, exp finish before 200000");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [10:0] a, input logic w,
                          input logic [3:0] s, input logic [31:0] d);
      req_addr[i*11 +: 11]  = a;
      req_write[i]          = w;
      req_strb[i*4 +: 4]    = s;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 2'b11; req_addr = '0; req_write = '0; req_strb = '0;
      req_wdata = '0; prdata = 32'hDEAD_BEEF; pready = 1'b1; pslverr = 1'b1;
      repeat (3) tick();
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 00", req_ready); end
      n_checks++; if ({psel, penable, busy} !== 3'b000) begin n_errors++; $display("FAIL rst_psel_penable_busy: got %b exp 000", {psel, penable, busy}); end
      n_checks++; if ({paddr, pwrite, pstrb, pwdata} !== '0) begin n_errors++; $display("FAIL rst_apb_bus: got %h exp 0", {paddr, pwrite, pstrb, pwdata}); end
      n_checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin n_errors++; $display("FAIL rst_rsp: got %h exp 0", {rsp_valid, rsp_rdata, rsp_err}); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      req_valid = 2'b00; pready = 1'b0; pslverr = 1'b0; prdata = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      set_req(0, 11'h010, 1'b1, 4'hF, 32'hA5A5_0001);
      req_valid = 2'b01; #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL wr_req_ready: got %b exp 01", req_ready); end
      tick();
      req_valid = 2'b00; pready = 1'b1;
      n_checks++; if ({psel, penable} !== 2'b10) begin n_errors++; $display("FAIL wr_setup: got %b exp 10", {psel, penable}); end
      n_checks++; if ({paddr, pwrite, pstrb, pwdata} !== {11'h010, 1'b1, 4'hF, 32'hA5A5_0001}) begin
         n_errors++; $display("FAIL wr_bus: got %h/%b/%h/%h exp 010/1/f/a5a50001", paddr, pwrite, pstrb, pwdata); end
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL wr_ready_setup: got %b exp 00", req_ready); end
      tick();
      n_checks++; if ({psel, penable, busy} !== 3'b111) begin n_errors++; $display("FAIL wr_access: got %b exp 111", {psel, penable, busy}); end
      tick();
      pready = 1'b0;
      n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0}) begin
         n_errors++; $display("FAIL wr_rsp: got %b/%b/%h exp 01/0/0", rsp_valid, rsp_err, rsp_rdata); end
      n_checks++; if ({psel, penable, busy} !== 3'b000) begin n_errors++; $display("FAIL wr_idle: got %b exp 000", {psel, penable, busy}); end
      tick();
      n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL wr_rsp_pulse: got %b exp 00", rsp_valid); end
   endtask

   task automatic test_read_wait();
      set_req(1, 11'h004, 1'b0, 4'hF, 32'h1234_5678);
      prdata = 32'hDEAD_0000;
      req_valid = 2'b10; #1;
      n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL rd_req_ready: got %b exp 10", req_ready); end
      tick();
      req_valid = 2'b00;
      n_checks++; if ({paddr, pwrite, pstrb} !== {11'h004, 1'b0, 4'h0}) begin
         n_errors++; $display("FAIL rd_bus: got %h/%b/%h exp 004/0/0", paddr, pwrite, pstrb); end
      for (int w = 0; w < 3; w++) begin
         tick();
         n_checks++; if ({psel, penable, pstrb} !== {2'b11, 4'h0}) begin
            n_errors++; $display("FAIL rd_wait%0d: got %b/%h exp 11/0", w, {psel, penable}, pstrb); end
      end
      tick();
      pready = 1'b1; prdata = 32'h0000_00FF;
      n_checks++; if ({psel, penable, paddr} !== {2'b11, 11'h004}) begin
         n_errors++; $display("FAIL rd_last_access: got %b/%h exp 11/004", {psel, penable}, paddr); end
      tick();
      pready = 1'b0; prdata = '0;
      n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0000_00FF}) begin
         n_errors++; $display("FAIL rd_rsp: got %b/%b/%h exp 10/0/000000ff", rsp_valid, rsp_err, rsp_rdata); end
      tick();
   endtask

   task automatic test_contention();
      logic [N-1:0] g;
      set_req(0, 11'h100, 1'b1, 4'h3, 32'h0000_1000);
      set_req(1, 11'h200, 1'b1, 4'hC, 32'h0000_2000);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      req_valid = 2'b11; pready = 1'b1; #1;
      for (int t = 0; t < 4; t++) begin
         g = exp_q.pop_front();
         n_checks++; if (req_ready !== g) begin n_errors++; $display("FAIL rr_grant%0d: got %b exp %b", t, req_ready, g); end
         tick();
         n_checks++; if (paddr !== ((g == 2'b01) ? 11'h100 : 11'h200)) begin
            n_errors++; $display("FAIL rr_addr%0d: got %h exp %h", t, paddr, (g == 2'b01) ? 11'h100 : 11'h200); end
         tick();
         tick();
         n_checks++; if (rsp_valid !== g) begin n_errors++; $display("FAIL rr_rsp%0d: got %b exp %b", t, rsp_valid, g); end
      end
      req_valid = 2'b00; pready = 1'b0;
      tick();
   endtask

   task automatic test_slverr();
      set_req(1, 11'h7FC, 1'b1, 4'hF, 32'hCAFE_F00D);
      req_valid = 2'b10; prdata = 32'h5555_AAAA;
      tick();
      req_valid = 2'b00;
      n_checks++; if ({paddr, pwrite} !== {11'h7FC, 1'b1}) begin n_errors++; $display("FAIL err_bus: got %h/%b exp 7fc/1", paddr, pwrite); end
      tick();
      pready = 1'b1; pslverr = 1'b1;
      tick();
      pready = 1'b0; pslverr = 1'b0;
      n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
         n_errors++; $display("FAIL err_rsp: got %b/%b/%h exp 10/1/0", rsp_valid, rsp_err, rsp_rdata); end
      tick();
   endtask

   task automatic test_timeout();
      set_req(0, 11'h123, 1'b0, 4'h0, 32'h0);
      req_valid = 2'b01; pready = 1'b0; prdata = 32'h7777_7777;
      tick();
      req_valid = 2'b00;
      for (int w = 0; w < 4; w++) begin
         tick();
         n_checks++; if ({psel, penable} !== 2'b11) begin n_errors++; $display("FAIL to_access%0d: got %b exp 11", w, {psel, penable}); end
      end
      tick();
      n_checks++; if ({psel, penable, busy} !== 3'b000) begin n_errors++; $display("FAIL to_drop: got %b exp 000", {psel, penable, busy}); end
      n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin
         n_errors++; $display("FAIL to_rsp: got %b/%b/%h exp 01/1/0", rsp_valid, rsp_err, rsp_rdata); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_errors++; $display("FAIL to_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      prdata = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      set_req(0, 11'h3AA, 1'b1, 4'h5, 32'h0BAD_0BAD);
      set_req(1, 11'h055, 1'b1, 4'hA, 32'h0600_D000);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      n_checks++; if (dbg_state !== ST_ACCESS) begin n_errors++; $display("FAIL mr_in_access: got %0d exp %0d", dbg_state, ST_ACCESS); end
      rst_n = 1'b0; #1;
      n_checks++; if ({psel, penable, busy, paddr, pwrite, pstrb, pwdata} !== '0) begin
         n_errors++; $display("FAIL mr_outputs: got %b%b%b/%h/%h/%h exp all 0", psel, penable, busy, paddr, pstrb, pwdata); end
      tick();
      rst_n = 1'b1; pready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if ({rsp_valid, psel} !== 3'b000) begin n_errors++; $display("FAIL mr_no_rsp%0d: got %b/%b exp 00/0", c, rsp_valid, psel); end
      end
      pready = 1'b0; req_valid = 2'b11; #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL mr_first_grant: got %b exp 01", req_ready); end
      tick();
      req_valid = 2'b00;
      n_checks++; if (paddr !== 11'h3AA) begin n_errors++; $display("FAIL mr_first_addr: got %h exp 3aa", paddr); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_contention();
      test_slverr();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
